// File: rtl/cal_bus_arb.sv
// cal_bus_arb: registered data-bus source selector, legacy dmux or round-robin arbitration
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   mode_sel  0 = legacy dmux select, 1 = round-robin arbitration
//   dmux      legacy source index (out-of-range falls back to DEF_SRC)
//   src_data  packed sources, source i = src_data[i*DW +: DW]
//   src_req   per-source bus request (arbitrated mode)
//   grant     one-hot owner of data_bus, or all-zero
//   data_bus  registered bus data
//   bus_valid data_bus carries a granted source
module cal_bus_arb #(
    parameter int NSRC     = 4,
    parameter int DW       = 8,
    parameter int SELW     = 3,
    parameter int DEF_SRC  = 1,
    parameter int MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mode_sel,
    input  logic [SELW-1:0]      dmux,
    input  logic [NSRC*DW-1:0]   src_data,
    input  logic [NSRC-1:0]      src_req,
    output logic [NSRC-1:0]      grant,
    output logic [DW-1:0]        data_bus,
    output logic                 bus_valid
);
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD - 1);
    logic [NSRC-1:0] grant_q, grant_d;
    logic [DW-1:0]   data_q, data_d;
    logic            valid_q, valid_d;
    logic [SELW-1:0] rr_ptr_q, rr_ptr_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic            mode_q, mode_d;
    logic [SELW-1:0] own_idx, nxt_idx;
    logic [SELW:0]   from_ptr, from_own;
    logic            own, nxt_vld;
    // First requester at or after start in circular order; msb flags a hit.
    function automatic logic [SELW:0] pick(input logic [NSRC-1:0] req, input int start);
        logic [SELW:0] r;
        int j;
        r = '0;
        for (int k = NSRC - 1; k >= 0; k--) begin
            j = (start + k) % NSRC;
            if (req[j]) r = {1'b1, SELW'(j)};
        end
        return r;
    endfunction
    always_comb begin
        own_idx = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (grant_q[i]) own_idx = SELW'(i);
        end
    end
    // Ownership only counts as arbitrated if the previous cycle was arbitrated;
    // coming out of legacy mode the search restarts from rr_ptr.
    assign own      = mode_q & (|grant_q);
    assign from_ptr = pick(src_req, int'(rr_ptr_q));
    assign from_own = pick(src_req, int'(own_idx) + 1);
    always_comb begin
        nxt_vld  = 1'b0;
        nxt_idx  = '0;
        hold_d   = '0;
        rr_ptr_d = rr_ptr_q;
        mode_d   = mode_sel;
        if (!mode_sel) begin
            nxt_vld = 1'b1;
            nxt_idx = (int'(dmux) < NSRC) ? dmux : SELW'(DEF_SRC);
        end else if (!own) begin
            nxt_vld = from_ptr[SELW];
            nxt_idx = from_ptr[SELW-1:0];
        end else if (!src_req[own_idx] || (hold_q == HOLD_MAX && |(src_req & ~grant_q))) begin
            nxt_vld = from_own[SELW];
            nxt_idx = from_own[SELW-1:0];
        end else begin
            nxt_vld = 1'b1;
            nxt_idx = own_idx;
            hold_d  = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
        end
        if (mode_sel && nxt_vld && (!own || nxt_idx != own_idx)) begin
            hold_d   = '0;
            rr_ptr_d = (int'(nxt_idx) == NSRC - 1) ? '0 : nxt_idx + 1'b1;
        end
        grant_d = nxt_vld ? (NSRC'(1) << nxt_idx) : '0;
        data_d  = nxt_vld ? src_data[int'(nxt_idx)*DW +: DW] : '0;
        valid_d = nxt_vld;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q  <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            rr_ptr_q <= '0;
            hold_q   <= '0;
            mode_q   <= 1'b0;
        end else begin
            grant_q  <= grant_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            rr_ptr_q <= rr_ptr_d;
            hold_q   <= hold_d;
            mode_q   <= mode_d;
        end
    end
    assign grant     = grant_q;
    assign data_bus  = data_q;
    assign bus_valid = valid_q;
endmodule

// File: tb/tb_cal_bus_arb.sv
// tb_cal_bus_arb: table, directed and random checks of cal_bus_arb against a reference model
module tb_cal_bus_arb;
    localparam int MH = 8;
    typedef struct {
        logic       mode;
        logic [2:0] dmux;
        logic [3:0] req;
        logic [3:0] grant;
        logic [7:0] data;
        logic       valid;
    } vec_t;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        mode_sel = 1'b0;
    logic [2:0]  dmux = '0;
    logic [31:0] src_data = '0;
    logic [3:0]  src_req = '0;
    logic [3:0]  grant;
    logic [7:0]  data_bus;
    logic        bus_valid;
    int total = 0;
    int bad = 0;
    int m_owner = -1;
    int m_rr = 0;
    int m_hold = 0;
    logic m_prev = 1'b0;
    logic [3:0] e_grant;
    logic [7:0] e_data;
    logic       e_valid;
    vec_t tbl[12];
    always #5 clk = ~clk;
    cal_bus_arb dut (
        .clk(clk), .rst_n(rst_n), .mode_sel(mode_sel), .dmux(dmux),
        .src_data(src_data), .src_req(src_req),
        .grant(grant), .data_bus(data_bus), .bus_valid(bus_valid)
    );
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask
    function automatic int next_req(input logic [3:0] req, input int start);
        for (int k = 0; k < 4; k++) begin
            if (req[(start + k) % 4]) return (start + k) % 4;
        end
        return -1;
    endfunction
    // Reference: owner as an integer (-1 = idle), evaluated once per clock edge.
    task automatic model_edge();
        int o;
        if (!mode_sel) begin
            o = (dmux < 4) ? int'(dmux) : 1;
            m_hold = 0;
        end else begin
            if (!m_prev || m_owner < 0) o = next_req(src_req, m_rr);
            else if (!src_req[m_owner]) o = next_req(src_req, m_owner + 1);
            else if (m_hold == MH - 1 && (src_req & ~(4'b1 << m_owner)) != 0) o = next_req(src_req, m_owner + 1);
            else begin
                o = m_owner;
                m_hold = (m_hold < MH - 1) ? m_hold + 1 : MH - 1;
            end
            if (o < 0) m_hold = 0;
            else if (!m_prev || m_owner < 0 || o != m_owner) begin
                m_hold = 0;
                m_rr = (o + 1) % 4;
            end
        end
        e_grant = (o < 0) ? 4'b0 : (4'b1 << o);
        e_data  = (o < 0) ? 8'h00 : src_data[o*8 +: 8];
        e_valid = (o >= 0);
        m_owner = o;
        m_prev  = mode_sel;
    endtask
    task automatic step(input logic m, input logic [2:0] d, input logic [3:0] r, input logic [31:0] s);
        mode_sel = m;
        dmux = d;
        src_req = r;
        src_data = s;
        @(posedge clk);
        model_edge();
        #1;
        check("model_grant", grant, e_grant);
        check("model_data", data_bus, e_data);
        check("model_valid", bus_valid, e_valid);
    endtask
    task automatic do_reset();
        rst_n = 1'b0;
        m_owner = -1;
        m_rr = 0;
        m_hold = 0;
        m_prev = 1'b0;
        #1;
        check("rst_grant", grant, 4'b0);
        check("rst_data", data_bus, 8'h00);
        check("rst_valid", bus_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask
    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
    initial begin
        logic [31:0] src;
        logic [3:0] r;
        src = {8'h3C, 8'hA5, 8'h5A, 8'h11};
        tbl[0]  = '{1'b0, 3'd2, 4'b0000, 4'b0100, 8'hA5, 1'b1};
        tbl[1]  = '{1'b0, 3'd7, 4'b0000, 4'b0010, 8'h5A, 1'b1};
        tbl[2]  = '{1'b0, 3'd4, 4'b1111, 4'b0010, 8'h5A, 1'b1};
        tbl[3]  = '{1'b0, 3'd3, 4'b0000, 4'b1000, 8'h3C, 1'b1};
        tbl[4]  = '{1'b1, 3'd0, 4'b1111, 4'b0001, 8'h11, 1'b1};
        tbl[5]  = '{1'b1, 3'd0, 4'b1110, 4'b0010, 8'h5A, 1'b1};
        tbl[6]  = '{1'b1, 3'd0, 4'b1101, 4'b0100, 8'hA5, 1'b1};
        tbl[7]  = '{1'b1, 3'd0, 4'b1011, 4'b1000, 8'h3C, 1'b1};
        tbl[8]  = '{1'b1, 3'd0, 4'b0111, 4'b0001, 8'h11, 1'b1};
        tbl[9]  = '{1'b1, 3'd0, 4'b0000, 4'b0000, 8'h00, 1'b0};
        tbl[10] = '{1'b1, 3'd0, 4'b0000, 4'b0000, 8'h00, 1'b0};
        tbl[11] = '{1'b1, 3'd0, 4'b0100, 4'b0100, 8'hA5, 1'b1};
        #3;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].mode, tbl[i].dmux, tbl[i].req, src);
            check("tbl_grant", grant, tbl[i].grant);
            check("tbl_data", data_bus, tbl[i].data);
            check("tbl_valid", bus_valid, tbl[i].valid);
        end
        do_reset();
        for (int k = 0; k < 17; k++) begin
            step(1'b1, 3'd0, 4'b0011, src);
            check("hold_grant", grant, ((k / 8) % 2 == 1) ? 4'b0010 : 4'b0001);
        end
        do_reset();
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 3'd0, 4'b1000, src);
            check("sole_grant", grant, 4'b1000);
        end
        step(1'b1, 3'd0, 4'b0000, src);
        check("sole_rel_grant", grant, 4'b0000);
        check("sole_rel_valid", bus_valid, 1'b0);
        check("sole_rel_data", data_bus, 8'h00);
        do_reset();
        step(1'b1, 3'd0, 4'b0100, src);
        check("mid_own2", grant, 4'b0100);
        step(1'b0, 3'd0, 4'b0100, src);
        check("mid_legacy", grant, 4'b0001);
        step(1'b1, 3'd0, 4'b0100, src);
        check("mid_back_arb", grant, 4'b0100);
        #2;
        do_reset();
        step(1'b1, 3'd0, 4'b1010, src);
        check("post_rst_lowest", grant, 4'b0010);
        do_reset();
        r = 4'b0011;
        for (int n = 0; n < 600; n++) begin
            if ($urandom % 4 == 0) r = 4'($urandom);
            step(($urandom % 6) != 0, 3'($urandom), r, $urandom);
            if ($urandom % 150 == 0) do_reset();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
